// File: rtl/vga_pkg.sv
// Shared VGA timing constants and cursor-scheduler types.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 800;
  localparam int unsigned VGA_V_ACTIVE = 600;

  typedef enum logic {IDLE, PENDING} mouse_sched_state_t;

  function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mouse_pos_sched.sv
// Cursor position scheduler: stages clamped updates and commits them at vblank
// start so the cursor never tears; auto-hides the cursor after idle frames.
module mouse_pos_sched
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned HIDE_FRAMES = 180
) (
  input  logic        clk40,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        mouse_en,
  output logic        frame_tick
);

  localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - 1);
  localparam logic [15:0] HIDE_MAX = 16'(HIDE_FRAMES);

  mouse_sched_state_t state, state_next;

  logic        vblnk_d;
  logic        rise;
  logic        transfer;
  logic [11:0] x_cl, y_cl;
  logic [11:0] st_x, st_y, st_x_next, st_y_next;
  logic        commit, changed;
  logic [11:0] cm_x, cm_y;
  logic [15:0] idle_cnt;
  logic [15:0] idle_inc;

  always_comb begin
    transfer   = pos_valid && pos_ready;
    rise       = vblnk && !vblnk_d;
    x_cl       = clamp12(xpos_in, X_MAX);
    y_cl       = clamp12(ypos_in, Y_MAX);
    state_next = state;
    st_x_next  = st_x;
    st_y_next  = st_y;
    commit     = 1'b0;
    cm_x       = st_x;
    cm_y       = st_y;

    // A transfer landing on the rise edge bypasses staging and commits directly.
    unique case (state)
      IDLE: begin
        if (transfer) begin
          if (rise) begin
            commit = 1'b1;
            cm_x   = x_cl;
            cm_y   = y_cl;
          end else begin
            st_x_next  = x_cl;
            st_y_next  = y_cl;
            state_next = PENDING;
          end
        end
      end
      PENDING: begin
        if (rise) begin
          commit     = 1'b1;
          state_next = IDLE;
          if (transfer) begin
            cm_x = x_cl;
            cm_y = y_cl;
          end
        end else if (transfer) begin
          st_x_next = x_cl;
          st_y_next = y_cl;
        end
      end
      default: state_next = IDLE;
    endcase

    changed  = commit && ((cm_x != xpos) || (cm_y != ypos));
    idle_inc = idle_cnt + 16'd1;
  end

  always_ff @(posedge clk40) begin
    if (rst) begin
      state      <= IDLE;
      vblnk_d    <= 1'b0;
      frame_tick <= 1'b0;
      pos_ready  <= 1'b0;
      st_x       <= '0;
      st_y       <= '0;
      xpos       <= '0;
      ypos       <= '0;
      mouse_en   <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_next;
      vblnk_d    <= vblnk;
      frame_tick <= rise;
      pos_ready  <= 1'b1;
      st_x       <= st_x_next;
      st_y       <= st_y_next;
      if (changed) begin
        xpos     <= cm_x;
        ypos     <= cm_y;
        idle_cnt <= '0;
        mouse_en <= 1'b1;
      end else if (rise && (idle_cnt != HIDE_MAX)) begin
        // HIDE_MAX==0 keeps the counter at 0, so the cursor is never hidden.
        idle_cnt <= idle_inc;
        if (idle_inc == HIDE_MAX) mouse_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mouse_pos_sched.sv
// Scoreboard bench for mouse_pos_sched: stimulus queues the expected commit per frame,
// a monitor compares on every frame_tick.
module tb_mouse_pos_sched;

  logic        clk40 = 1'b0;
  logic        rst;
  logic        vblnk;
  logic        pos_valid;
  logic        pos_ready;
  logic [11:0] xpos_in, ypos_in;
  logic [11:0] xpos, ypos;
  logic        mouse_en;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  bit seen_10 = 1'b0;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        en;
  } exp_t;

  exp_t sb[$];

  always #5 clk40 = ~clk40;

  mouse_pos_sched #(.H_ACTIVE(800), .V_ACTIVE(600), .HIDE_FRAMES(3)) dut (
    .clk40(clk40), .rst(rst), .vblnk(vblnk), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .xpos_in(xpos_in), .ypos_in(ypos_in), .xpos(xpos), .ypos(ypos),
    .mouse_en(mouse_en), .frame_tick(frame_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk40) begin
    if (xpos == 12'd10 && ypos == 12'd10) seen_10 = 1'b1;
    if (!rst && frame_tick) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("xpos", 32'(xpos), 32'(e.x));
        check("ypos", 32'(ypos), 32'(e.y));
        check("mouse_en", 32'(mouse_en), 32'(e.en));
      end
    end
  end

  task automatic push(input logic [11:0] x, input logic [11:0] y, input logic en);
    exp_t e;
    e.x = x; e.y = y; e.en = en;
    sb.push_back(e);
  endtask

  task automatic send(input logic [11:0] x, input logic [11:0] y);
    pos_valid = 1'b1; xpos_in = x; ypos_in = y;
    @(posedge clk40); #1;
    pos_valid = 1'b0;
  endtask

  task automatic do_frame();
    vblnk = 1'b1;
    repeat (4) @(posedge clk40);
    #1 vblnk = 1'b0;
    repeat (8) @(posedge clk40);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vblnk = 1'b0; pos_valid = 1'b0; xpos_in = '0; ypos_in = '0;
    repeat (3) @(posedge clk40);
    #1;
    check("rst_xpos", 32'(xpos), 32'd0);
    check("rst_ypos", 32'(ypos), 32'd0);
    check("rst_en", 32'(mouse_en), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_ready", 32'(pos_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk40); #1;
    check("ready_after_rst", 32'(pos_ready), 32'd1);
    repeat (3) @(posedge clk40); #1;

    // Update mid-frame stays invisible until the vblank rise.
    send(12'd100, 12'd200);
    repeat (5) @(posedge clk40); #1;
    check("hold_xpos", 32'(xpos), 32'd0);
    check("hold_ypos", 32'(ypos), 32'd0);
    check("hold_en", 32'(mouse_en), 32'd0);
    push(12'd100, 12'd200, 1'b1);
    do_frame();

    // Latest wins.
    send(12'd10, 12'd10);
    repeat (2) @(posedge clk40); #1;
    send(12'd20, 12'd30);
    push(12'd20, 12'd30, 1'b1);
    do_frame();

    // Clamping.
    send(12'd900, 12'd700);
    push(12'd799, 12'd599, 1'b1);
    do_frame();
    send(12'd4095, 12'd0);
    push(12'd799, 12'd0, 1'b1);
    do_frame();

    // Transfer on the exact rise cycle.
    vblnk = 1'b1; pos_valid = 1'b1; xpos_in = 12'd50; ypos_in = 12'd60;
    push(12'd50, 12'd60, 1'b1);
    @(posedge clk40); #1;
    pos_valid = 1'b0;
    check("bypass_state_idle", 32'(dut.state), 32'(vga_pkg::IDLE));
    repeat (3) @(posedge clk40);
    #1 vblnk = 1'b0;
    repeat (8) @(posedge clk40); #1;
    push(12'd50, 12'd60, 1'b1);
    do_frame();

    // Hiding after 3 idle frames.
    send(12'd5, 12'd5);
    push(12'd5, 12'd5, 1'b1);
    do_frame();
    push(12'd5, 12'd5, 1'b1);
    do_frame();
    push(12'd5, 12'd5, 1'b1);
    do_frame();
    push(12'd5, 12'd5, 1'b0);
    do_frame();
    send(12'd5, 12'd5);
    push(12'd5, 12'd5, 1'b0);
    do_frame();
    send(12'd6, 12'd5);
    push(12'd6, 12'd5, 1'b1);
    do_frame();

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("never_10_10", 32'(seen_10), 32'd0);
    check("ready_steady", 32'(pos_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
